// File: rtl/write_back_arbiter.sv
// Write-back arbiter: merges pipeline writes with a queued debug port.
// Optional WB_ARB_STATS_EN builds the debug commit counter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } arb_state_t;

  function automatic int clogb2(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    for (int i = 0; i < 32; i++) begin
      if (x > 0) begin
        r++;
        x = x >> 1;
      end
    end
    return r;
  endfunction

endpackage

module write_back_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int CANT_REGISTROS      = 32,
  parameter  int CANT_BITS_REGISTROS = 32,
  parameter  int FIFO_DEPTH          = 4,
  parameter  int MAX_WAIT            = 8,
  localparam int AW = clogb2(CANT_REGISTROS - 1),
  localparam int DW = CANT_BITS_REGISTROS
) (
  input  logic          i_clock,
  input  logic          i_soft_reset,
  input  logic [AW-1:0] i_registro_destino,
  input  logic [DW-1:0] i_data_write,
  input  logic          i_RegWrite,
  input  logic          i_dbg_valid,
  input  logic [AW-1:0] i_dbg_registro,
  input  logic [DW-1:0] i_dbg_data,
  output logic          o_dbg_ready,
  output logic          o_rf_we,
  output logic [AW-1:0] o_rf_addr,
  output logic [DW-1:0] o_rf_data,
  output logic          o_stall,
  output logic          o_dbg_pending,
  output logic [15:0]   o_dbg_commits
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [AW-1:0] q_addr [FIFO_DEPTH];
  logic [DW-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nx;
  arb_state_t    state;
  arb_state_t    state_nx;

  logic          push;
  logic          pop;
  logic          grant_p;
  logic          lost;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign o_dbg_ready   = (count != FULL);
  assign o_dbg_pending = (count != '0);
  assign push          = i_dbg_valid && o_dbg_ready;
  assign head_addr     = q_addr[rd_ptr];
  assign head_data     = q_data[rd_ptr];

  // During a forced slot the pipeline is ignored; otherwise it has priority.
  assign pop     = o_stall || (o_dbg_pending && !i_RegWrite);
  assign grant_p = !o_stall && i_RegWrite;
  assign lost    = (state == PEND) && grant_p;

  assign count_nx = count
                  + {{(CW-1){1'b0}}, push}
                  - {{(CW-1){1'b0}}, pop};

  // Next wait count and next state; starvation of the queue forces a slot.
  always_comb begin
    wait_nx  = wait_cnt;
    state_nx = (count_nx != '0) ? PEND : IDLE;
    if (state == IDLE || pop) begin
      wait_nx = '0;
    end else if (lost && wait_cnt != WMAX) begin
      wait_nx = wait_cnt + 1'b1;
    end
    if (lost && wait_nx == WMAX) begin
      state_nx = FORCE;
    end
  end

  // Arbiter state, wait counter and registered stall flag.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      o_stall  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      o_stall  <= (state_nx == FORCE);
    end
  end

  // Debug queue pointers and occupancy.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
    end
  end

  // Queue storage; no reset needed since occupancy gates every read.
  always_ff @(posedge i_clock) begin
    if (push) begin
      q_addr[wr_ptr] <= i_dbg_registro;
      q_data[wr_ptr] <= i_dbg_data;
    end
  end

  // Registered register-file port; register 0 is never written.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      o_rf_we   <= 1'b0;
      o_rf_addr <= '0;
      o_rf_data <= '0;
    end else if (pop) begin
      o_rf_we   <= (head_addr != '0);
      o_rf_addr <= head_addr;
      o_rf_data <= head_data;
    end else if (grant_p) begin
      o_rf_we   <= (i_registro_destino != '0);
      o_rf_addr <= i_registro_destino;
      o_rf_data <= i_data_write;
    end else begin
      o_rf_we   <= 1'b0;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [15:0] commits;

  // Count debug writes that actually reach the register file.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      commits <= '0;
    end else if (pop && head_addr != '0) begin
      commits <= commits + 16'd1;
    end
  end

  assign o_dbg_commits = commits;
`else
  assign o_dbg_commits = '0;
`endif

endmodule

// File: tb/tb_write_back_arbiter.sv
// Bench for write_back_arbiter: per-source write scoreboards,
// plus directed checks on stall timing, backpressure and reset.
module tb_write_back_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int MW  = 8;
  localparam int DEP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd = '0;
  logic [DW-1:0] wd = '0;
  logic          rw = 1'b0;
  logic          dv = 1'b0;
  logic [AW-1:0] dr = '0;
  logic [DW-1:0] dd = '0;
  logic          rdy;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          stall;
  logic          pend;
  logic [15:0]   commits;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t pq[$];
  wr_t dq[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  exp_commits = 0;

  always #5 clk = ~clk;

  write_back_arbiter #(
    .CANT_REGISTROS(32),
    .CANT_BITS_REGISTROS(DW),
    .FIFO_DEPTH(DEP),
    .MAX_WAIT(MW)
  ) dut (
    .i_clock(clk),
    .i_soft_reset(rst_n),
    .i_registro_destino(rd),
    .i_data_write(wd),
    .i_RegWrite(rw),
    .i_dbg_valid(dv),
    .i_dbg_registro(dr),
    .i_dbg_data(dd),
    .o_dbg_ready(rdy),
    .o_rf_we(rf_we),
    .o_rf_addr(rf_addr),
    .o_rf_data(rf_data),
    .o_stall(stall),
    .o_dbg_pending(pend),
    .o_dbg_commits(commits)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_c();
`ifdef WB_ARB_STATS_EN
    return 16'(exp_commits);
`else
    return 16'd0;
`endif
  endfunction

  // Record what this cycle should commit, clock it, then match writes.
  task automatic cycle();
    wr_t e;
    if (rw && !stall && rd != '0) pq.push_back('{rd, wd});
    if (dv && rdy && dr != '0) dq.push_back('{dr, dd});
    @(posedge clk);
    #1;
    if (rf_we) begin
      if (rf_data >= 32'h1000) begin
        check("pipe_wr_expected", 64'(pq.size() != 0), 64'd1);
        if (pq.size() != 0) begin
          e = pq.pop_front();
          check("pipe_addr", 64'(rf_addr), 64'(e.a));
          check("pipe_data", 64'(rf_data), 64'(e.d));
        end
      end else begin
        check("dbg_wr_expected", 64'(dq.size() != 0), 64'd1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          check("dbg_addr", 64'(rf_addr), 64'(e.a));
          check("dbg_data", 64'(rf_data), 64'(e.d));
          exp_commits++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic        acc;
    int          k;
    logic [DW-1:0] pd;

    #1;
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_addr", 64'(rf_addr), 64'd0);
    check("rst_data", 64'(rf_data), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_pend", 64'(pend), 64'd0);
    check("rst_ready", 64'(rdy), 64'd1);
    check("rst_commits", 64'(commits), 64'd0);
    #21;
    rst_n = 1'b1;

    // Single pipeline write, one-cycle latency.
    rw = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF;
    cycle();
    check("pipe_we", 64'(rf_we), 64'd1);
    check("pipe_a5", 64'(rf_addr), 64'd5);
    check("pipe_dead", 64'(rf_data), 64'hDEADBEEF);
    rw = 1'b0;
    cycle();
    check("idle_we", 64'(rf_we), 64'd0);

    // Two debug writes drained back to back.
    dv = 1'b1; dr = 5'd3; dd = 32'h11;
    cycle();
    check("dbg_pend1", 64'(pend), 64'd1);
    dr = 5'd4; dd = 32'h22;
    cycle();
    dv = 1'b0;
    check("dbg_we3", 64'(rf_we), 64'd1);
    check("dbg_a3", 64'(rf_addr), 64'd3);
    cycle();
    check("dbg_a4", 64'(rf_addr), 64'd4);
    check("dbg_pend0", 64'(pend), 64'd0);
    check("commits_2", 64'(commits), 64'(exp_c()));

    // Starved debug entry gets exactly one forced slot.
    pd = 32'hA000_0000;
    rw = 1'b1; rd = 5'd7; wd = pd;
    dv = 1'b1; dr = 5'd9; dd = 32'h99;
    for (int i = 0; i < 12; i++) begin
      check("stall_sched", 64'(stall), 64'(i == MW + 1));
      s = stall;
      cycle();
      dv = 1'b0;
      if (!s) pd = pd + 1;
      wd = pd;
    end
    check("force_pend0", 64'(pend), 64'd0);
    check("force_dq", 64'(dq.size()), 64'd0);

    // Five pushes into a four-deep queue under constant pipeline load.
    k = 0;
    for (int i = 0; i < 80; i++) begin
      if (k == 5 && dq.size() == 0 && !pend) break;
      if (i == 4) check("ready_full", 64'(rdy), 64'd0);
      if (i == 9) check("ready_full_force", 64'(rdy), 64'd0);
      if (i == 10) check("ready_after_pop", 64'(rdy), 64'd1);
      dv = (k < 5);
      dr = 5'(16 + k);
      dd = 32'h100 + 32'(k);
      acc = dv && rdy;
      s = stall;
      cycle();
      if (acc) k++;
      if (!s) pd = pd + 1;
      wd = pd;
    end
    dv = 1'b0;
    check("fill_done", 64'(k == 5 && dq.size() == 0), 64'd1);
    rw = 1'b0;
    cycle();
    check("commits_fill", 64'(commits), 64'(exp_c()));

    // Register 0 is never written from either source.
    rw = 1'b1; rd = 5'd0; wd = 32'hA000_0BAD;
    cycle();
    check("r0_pipe_we", 64'(rf_we), 64'd0);
    rw = 1'b0;
    dv = 1'b1; dr = 5'd0; dd = 32'h55;
    cycle();
    dv = 1'b0;
    check("r0_pend1", 64'(pend), 64'd1);
    cycle();
    check("r0_dbg_we", 64'(rf_we), 64'd0);
    check("r0_pend0", 64'(pend), 64'd0);
    check("r0_commits", 64'(commits), 64'(exp_c()));

    // Reset with three entries queued discards them.
    rw = 1'b1; rd = 5'd8; wd = pd;
    for (int i = 0; i < 3; i++) begin
      dv = 1'b1; dr = 5'(21 + i); dd = 32'h300 + 32'(i);
      cycle();
      pd = pd + 1;
      wd = pd;
    end
    dv = 1'b0; rw = 1'b0;
    check("pre_rst_pend", 64'(pend), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    dq.delete();
    exp_commits = 0;
    check("arst_we", 64'(rf_we), 64'd0);
    check("arst_addr", 64'(rf_addr), 64'd0);
    check("arst_data", 64'(rf_data), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_pend", 64'(pend), 64'd0);
    check("arst_commits", 64'(commits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_ready", 64'(rdy), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rel_no_wr", 64'(rf_we), 64'd0);
    end
    check("rel_commits", 64'(commits), 64'd0);
    check("pipe_sb_drained", 64'(pq.size()), 64'd0);
    check("dbg_sb_drained", 64'(dq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
